// File: rtl/cenc_pkg.sv
// Shared types and constants for the rate-selectable convolutional encoder:
// code-rate enum, default generators and puncture keep masks.
package cenc_pkg;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2
    } rate_e;

    localparam logic [6:0] CENC_G0 = 7'o133;
    localparam logic [6:0] CENC_G1 = 7'o171;

    // keep mask bit 1 = output A, bit 0 = output B
    localparam logic [1:0] KEEP_AB = 2'b11;
    localparam logic [1:0] KEEP_A  = 2'b10;
    localparam logic [1:0] KEEP_B  = 2'b01;

    function automatic rate_e rate_decode(input logic [1:0] r);
        rate_e v;
        unique case (r)
            2'd1:    v = RATE_2_3;
            2'd2:    v = RATE_3_4;
            default: v = RATE_1_2;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] keep_mask(input rate_e r,
                                             input logic [1:0] ph);
        logic [1:0] m;
        unique case (r)
            RATE_2_3: m = (ph == 2'd0) ? KEEP_AB : KEEP_A;
            RATE_3_4: m = (ph == 2'd0) ? KEEP_AB :
                          (ph == 2'd1) ? KEEP_A  : KEEP_B;
            default:  m = KEEP_AB;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] phase_next(input rate_e r,
                                              input logic [1:0] ph);
        logic [1:0] n;
        unique case (r)
            RATE_2_3: n = (ph == 2'd1) ? 2'd0 : 2'd1;
            RATE_3_4: n = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cenc_conv_core.sv
// Convolutional encoder core: K-1 bit shift register and two parity trees.
// clr_i encodes the current bit against an all-zero history.
module cenc_conv_core
    import cenc_pkg::*;
#(
    parameter int           K  = 7,
    parameter logic [K-1:0] G0 = K'(CENC_G0),
    parameter logic [K-1:0] G1 = K'(CENC_G1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic ld_i,
    input  logic u_i,
    output logic a_o,
    output logic b_o
);

    logic [K-2:0] s_q;
    logic [K-2:0] s_d;
    logic [K-2:0] s_v;

    // parity outputs and shift of the new bit into the history
    always_comb begin
        s_v = clr_i ? '0 : s_q;
        a_o = ^(G0 & {u_i, s_v});
        b_o = ^(G1 & {u_i, s_v});
        s_d = s_q;
        if (ld_i) begin
            s_d = {u_i, s_v[K-2:1]};
        end else if (clr_i) begin
            s_d = '0;
        end
    end

    // shift register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/cenc_rate_enc.sv
// Rate-selectable convolutional encoder with puncturing and handshakes.
// Define CENC_TAIL_EN to append K-1 zero tail bits; `do` is a keyword, so the coded bit is do_o.
module cenc_rate_enc
    import cenc_pkg::*;
#(
    parameter int           K  = 7,
    parameter logic [K-1:0] G0 = K'(CENC_G0),
    parameter logic [K-1:0] G1 = K'(CENC_G1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       di,
    input  logic       di_vld,
    input  logic       di_last,
    output logic       di_rdy,
    input  logic [1:0] rate,
    output logic       do_o,
    output logic       do_vld,
    output logic       do_last,
    input  logic       do_rdy
);

`ifdef CENC_TAIL_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_e;
    localparam logic [3:0] TL = 4'(K - 2);
    logic [3:0] tcnt_q;
    logic [3:0] tcnt_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA} state_e;
`endif

    state_e     state_q;
    state_e     state_d;
    rate_e      rate_q;
    rate_e      rate_d;
    rate_e      rate_cur;
    logic [1:0] ph_q;
    logic [1:0] ph_d;
    logic [1:0] ph_cur;
    logic [1:0] mask;
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    logic       b0_q, b0_d, b1_q, b1_d;
    logic       l0_q, l0_d, l1_q, l1_d;
    logic       free;
    logic       in_xfer;
    logic       tail_inj;
    logic       last_sym;
    logic       ld;
    logic       core_clr;
    logic       core_u;
    logic       core_a;
    logic       core_b;

    assign free    = (pend_q == 2'd0) || ((pend_q == 2'd1) && do_rdy);
`ifdef CENC_TAIL_EN
    assign di_rdy  = (state_q != S_TAIL) && free;
`else
    assign di_rdy  = free;
`endif
    assign in_xfer = di_vld && di_rdy;
    assign do_vld  = (pend_q != 2'd0);
    assign do_o    = b0_q;
    assign do_last = l0_q;

    // frame FSM, tail injection, rate latch and puncture phase
    always_comb begin
        state_d  = state_q;
        tail_inj = 1'b0;
        last_sym = 1'b0;
`ifdef CENC_TAIL_EN
        tcnt_d   = tcnt_q;
`endif
        unique case (state_q)
            S_IDLE, S_DATA: begin
                if (in_xfer) begin
                    if (di_last) begin
`ifdef CENC_TAIL_EN
                        state_d = S_TAIL;
                        tcnt_d  = '0;
`else
                        state_d  = S_IDLE;
                        last_sym = 1'b1;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
`ifdef CENC_TAIL_EN
            S_TAIL: begin
                if (free) begin
                    tail_inj = 1'b1;
                    tcnt_d   = tcnt_q + 4'd1;
                    if (tcnt_q == TL) begin
                        state_d  = S_IDLE;
                        last_sym = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        ld       = in_xfer || tail_inj;
        core_clr = in_xfer && (state_q == S_IDLE);
        core_u   = in_xfer ? di : 1'b0;
        rate_cur = (state_q == S_IDLE) ? rate_decode(rate) : rate_q;
        ph_cur   = (state_q == S_IDLE) ? 2'd0 : ph_q;
        mask     = keep_mask(rate_cur, ph_cur);
        rate_d   = core_clr ? rate_cur : rate_q;
        ph_d     = ld ? phase_next(rate_cur, ph_cur) : ph_q;
    end

    cenc_conv_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr_i (core_clr),
        .ld_i  (ld),
        .u_i   (core_u),
        .a_o   (core_a),
        .b_o   (core_b)
    );

    // two-entry pending buffer: pop head on transfer, refill when free
    always_comb begin
        pend_d = pend_q;
        b0_d   = b0_q;
        b1_d   = b1_q;
        l0_d   = l0_q;
        l1_d   = l1_q;
        if (do_vld && do_rdy) begin
            if (pend_q == 2'd2) begin
                b0_d   = b1_q;
                l0_d   = l1_q;
                pend_d = 2'd1;
            end else begin
                b0_d   = 1'b0;
                l0_d   = 1'b0;
                pend_d = 2'd0;
            end
        end
        if (ld) begin
            b1_d   = 1'b0;
            l1_d   = 1'b0;
            pend_d = 2'd1;
            unique case (mask)
                KEEP_A: begin
                    b0_d = core_a;
                    l0_d = last_sym;
                end
                KEEP_B: begin
                    b0_d = core_b;
                    l0_d = last_sym;
                end
                default: begin
                    b0_d   = core_a;
                    l0_d   = 1'b0;
                    b1_d   = core_b;
                    l1_d   = last_sym;
                    pend_d = 2'd2;
                end
            endcase
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rate_q  <= RATE_1_2;
            ph_q    <= 2'd0;
            pend_q  <= 2'd0;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
`ifdef CENC_TAIL_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            ph_q    <= ph_d;
            pend_q  <= pend_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
`ifdef CENC_TAIL_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_cenc_rate_enc.sv
// Directed testbench for cenc_rate_enc (K=7, generators 133/171 octal).
// Expectations follow CENC_TAIL_EN as defined for the build.
module tb_cenc_rate_enc;

    localparam int         K   = 7;
    localparam logic [6:0] TG0 = 7'o133;
    localparam logic [6:0] TG1 = 7'o171;
`ifdef CENC_TAIL_EN
    localparam bit TAIL = 1'b1;
`else
    localparam bit TAIL = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       di;
    logic       di_vld;
    logic       di_last;
    logic       di_rdy;
    logic [1:0] rate;
    logic       do_o;
    logic       do_vld;
    logic       do_last;
    logic       do_rdy;

    bit got_b[$];
    bit got_l[$];
    bit exp_b[$];
    bit exp_l[$];
    int nlast;
    int n_cmp;
    int n_bad;

    cenc_rate_enc #(.K(K)) dut (
        .clk     (clk),
        .rst     (rst),
        .di      (di),
        .di_vld  (di_vld),
        .di_last (di_last),
        .di_rdy  (di_rdy),
        .rate    (rate),
        .do_o    (do_o),
        .do_vld  (do_vld),
        .do_last (do_last),
        .do_rdy  (do_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && do_vld && do_rdy) begin
            got_b.push_back(do_o);
            got_l.push_back(do_last);
            if (do_last) nlast++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int bit_diff(input int base);
        for (int i = 0; i < exp_b.size(); i++) begin
            if (base + i >= got_b.size()) return i;
            if (got_b[base + i] != exp_b[i]) return i;
        end
        return -1;
    endfunction

    function automatic int last_diff(input int base);
        for (int i = 0; i < exp_l.size(); i++) begin
            if (base + i >= got_l.size()) return i;
            if (got_l[base + i] != exp_l[i]) return i;
        end
        return -1;
    endfunction

    // independent reference: direct convolution sum plus puncture table
    task automatic model_append(input bit d[$], input int r);
        bit         x[$];
        bit         a;
        bit         b;
        int         per;
        int         ph;
        logic [6:0] g0;
        logic [6:0] g1;
        g0 = TG0;
        g1 = TG1;
        x = d;
        if (TAIL) for (int i = 0; i < K - 1; i++) x.push_back(1'b0);
        per = (r == 1) ? 2 : (r == 2) ? 3 : 1;
        for (int i = 0; i < x.size(); i++) begin
            a = 1'b0;
            b = 1'b0;
            for (int j = 0; j < K; j++) begin
                if (i - j >= 0) begin
                    a ^= g0[K-1-j] & x[i-j];
                    b ^= g1[K-1-j] & x[i-j];
                end
            end
            ph = i % per;
            if (!(per == 3 && ph == 2)) begin
                exp_b.push_back(a);
                exp_l.push_back(1'b0);
            end
            if (ph == 0 || (per == 3 && ph == 2)) begin
                exp_b.push_back(b);
                exp_l.push_back(1'b0);
            end
        end
        exp_l[exp_l.size() - 1] = 1'b1;
    endtask

    task automatic send(input bit d[$], input logic [1:0] r,
                        input bit mark_last);
        bit acc;
        int t;
        foreach (d[i]) begin
            di      = d[i];
            di_vld  = 1'b1;
            di_last = mark_last && (i == d.size() - 1);
            rate    = r;
            acc     = 1'b0;
            t       = 0;
            while (!acc && t < 300) begin
                @(negedge clk);
                acc = di_rdy;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send: di_rdy stuck 0 at bit %0d", i);
                break;
            end
        end
        di_vld  = 1'b0;
        di_last = 1'b0;
    endtask

    task automatic wait_last(input int target);
        int t = 0;
        while (nlast < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (nlast < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_last: saw %0d do_last, want %0d",
                     nlast, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [13:0] v, input int n);
        exp_b.delete();
        exp_l.delete();
        for (int i = 0; i < n; i++) begin
            exp_b.push_back(v[n-1-i]);
            exp_l.push_back(i == n - 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        do_rdy = 1'b1;
        di = 1'b0;
        di_vld = 1'b0;
        di_last = 1'b0;
        rate = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (do_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset do: got %b want 0", do_o);
        end
        n_cmp++;
        if (do_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset do_vld: got %b want 0", do_vld);
        end
        n_cmp++;
        if (do_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset do_last: got %b want 0", do_last);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (di_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset di_rdy: got %b want 1", di_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse;
        bit d[$];
        int base = got_b.size();
        int lb = nlast;
        int e;
        if (TAIL) set_exp(14'b11011111001011, 14);
        else set_exp(14'b11, 2);
        d = {1'b1};
        send(d, 2'd0, 1'b1);
        wait_last(lb + 1);
        n_cmp++;
        if (got_b.size() - base !== exp_b.size()) begin
            n_bad++;
            $display("FAIL impulse len: got %0d want %0d",
                     got_b.size() - base, exp_b.size());
        end
        n_cmp++;
        e = bit_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL impulse bits: first diff at %0d, want -1", e);
        end
        n_cmp++;
        e = last_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL impulse last: first diff at %0d, want -1", e);
        end
    endtask

    task automatic test_rate34;
        bit d[$];
        int base = got_b.size();
        int lb = nlast;
        int e;
        if (TAIL) set_exp(14'b110010111111, 12);
        else set_exp(14'b1100, 4);
        d = {1'b1, 1'b0, 1'b1};
        send(d, 2'd2, 1'b1);
        wait_last(lb + 1);
        n_cmp++;
        if (got_b.size() - base !== exp_b.size()) begin
            n_bad++;
            $display("FAIL rate34 len: got %0d want %0d",
                     got_b.size() - base, exp_b.size());
        end
        n_cmp++;
        e = bit_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL rate34 bits: first diff at %0d, want -1", e);
        end
        n_cmp++;
        e = last_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL rate34 last: first diff at %0d, want -1", e);
        end
    endtask

    task automatic test_rate23;
        bit d[$];
        int base = got_b.size();
        int lb = nlast;
        int want;
        int e;
        want = TAIL ? 15 : 6;
        exp_b.delete();
        exp_l.delete();
        d = {1'b1, 1'b1, 1'b0, 1'b1};
        model_append(d, 1);
        send(d, 2'd1, 1'b1);
        wait_last(lb + 1);
        n_cmp++;
        if (got_b.size() - base !== want) begin
            n_bad++;
            $display("FAIL rate23 len: got %0d want %0d",
                     got_b.size() - base, want);
        end
        n_cmp++;
        e = bit_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL rate23 bits: first diff at %0d, want -1", e);
        end
        n_cmp++;
        e = last_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL rate23 last: first diff at %0d, want -1", e);
        end
    endtask

    task automatic test_backpressure;
        bit d[$];
        int base = got_b.size();
        int lb = nlast;
        int e;
        exp_b.delete();
        exp_l.delete();
        for (int i = 0; i < 64; i++) d.push_back(1'($urandom_range(0, 1)));
        model_append(d, 0);
        fork
            send(d, 2'd0, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #1 do_rdy = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    e = got_b.size() - base;
                    n_cmp++;
                    if (do_o !== exp_b[e] || do_last !== exp_l[e]) begin
                        n_bad++;
                        $display("FAIL stall hold %0d: got %b/%b want %b/%b",
                                 k, do_o, do_last, exp_b[e], exp_l[e]);
                    end
                    n_cmp++;
                    if (di_rdy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL stall di_rdy %0d: got %b want 0",
                                 k, di_rdy);
                    end
                end
                @(posedge clk);
                #1 do_rdy = 1'b1;
            end
        join
        wait_last(lb + 1);
        n_cmp++;
        if (got_b.size() - base !== exp_b.size()) begin
            n_bad++;
            $display("FAIL backpressure len: got %0d want %0d",
                     got_b.size() - base, exp_b.size());
        end
        n_cmp++;
        e = bit_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL backpressure bits: first diff at %0d, want -1", e);
        end
        n_cmp++;
        e = last_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL backpressure last: first diff at %0d, want -1", e);
        end
    endtask

    task automatic test_reserved_rate;
        bit d[$];
        int base = got_b.size();
        int lb = nlast;
        int e;
        exp_b.delete();
        exp_l.delete();
        d = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        model_append(d, 0);
        send(d, 2'd3, 1'b1);
        wait_last(lb + 1);
        n_cmp++;
        if (got_b.size() - base !== exp_b.size()) begin
            n_bad++;
            $display("FAIL reserved len: got %0d want %0d",
                     got_b.size() - base, exp_b.size());
        end
        n_cmp++;
        e = bit_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL reserved bits: first diff at %0d, want -1", e);
        end
    endtask

    task automatic test_back_to_back;
        bit d1[$];
        bit d2[$];
        int base = got_b.size();
        int lb = nlast;
        int e;
        exp_b.delete();
        exp_l.delete();
        d1 = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        d2 = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        model_append(d1, 2);
        model_append(d2, 1);
        send(d1, 2'd2, 1'b1);
        send(d2, 2'd1, 1'b1);
        wait_last(lb + 2);
        n_cmp++;
        if (got_b.size() - base !== exp_b.size()) begin
            n_bad++;
            $display("FAIL b2b len: got %0d want %0d",
                     got_b.size() - base, exp_b.size());
        end
        n_cmp++;
        e = bit_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL b2b bits: first diff at %0d, want -1", e);
        end
        n_cmp++;
        e = last_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL b2b last: first diff at %0d, want -1", e);
        end
    endtask

    task automatic test_reset_mid;
        bit d[$];
        int base;
        int lb = nlast;
        int e;
        for (int i = 0; i < 10; i++) d.push_back(1'($urandom_range(0, 1)));
        send(d, 2'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (do_o !== 1'b0 || do_vld !== 1'b0 || do_last !== 1'b0) begin
            n_bad++;
            $display("FAIL abort outputs: got %b%b%b want 000",
                     do_o, do_vld, do_last);
        end
        n_cmp++;
        if (nlast !== lb) begin
            n_bad++;
            $display("FAIL abort do_last count: got %0d want %0d", nlast, lb);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        base = got_b.size();
        exp_b.delete();
        exp_l.delete();
        d = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        model_append(d, 2);
        send(d, 2'd2, 1'b1);
        wait_last(lb + 1);
        n_cmp++;
        if (got_b.size() - base !== exp_b.size()) begin
            n_bad++;
            $display("FAIL post-reset len: got %0d want %0d",
                     got_b.size() - base, exp_b.size());
        end
        n_cmp++;
        e = bit_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL post-reset bits: first diff at %0d, want -1", e);
        end
        n_cmp++;
        e = last_diff(base);
        if (e !== -1) begin
            n_bad++;
            $display("FAIL post-reset last: first diff at %0d, want -1", e);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nlast = 0;
        test_reset();
        test_impulse();
        test_rate34();
        test_rate23();
        test_backpressure();
        test_reserved_rate();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cenc_rate_enc.md
# cenc_rate_enc

Parametrised, rate-selectable convolutional channel encoder for the payload path. It combines the convolutional encoder and puncturing unit into one single-clock block with valid/ready handshakes on both sides. Constraint length and generator polynomials are parameters, the code rate is selected per frame, and tail bits are generated automatically. It sits between the payload scrambler output and the interleaver, and replaces the separate encode/puncture pair for the payload.

## Interface
Parameters:
- `K`, 7: constraint length, legal range 3..9. The shift register holds K-1 bits.
- `G0`, 7'o133: generator for output A. The MSB taps the current input bit.
- `G1`, 7'o171: generator for output B. The MSB taps the current input bit.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `di`  in  1: payload bit.
- `di_vld`  in  1: `di` is valid.
- `di_last`  in  1: qualifies the final data bit of a frame.
- `di_rdy`  out  1: encoder can accept `di` this cycle.
- `rate`  in  2: code rate. 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 is reserved and treated as 1/2.
- `do`  out  1: coded, punctured bit.
- `do_vld`  out  1: `do` is valid.
- `do_last`  out  1: final coded bit of the frame.
- `do_rdy`  in  1: downstream accepts `do`.

## Operation
- Handshakes:
  - Input transfer occurs when `di_vld & di_rdy`.
  - Output transfer occurs when `do_vld & do_rdy`.
- FSM `IDLE -> DATA -> TAIL -> IDLE`:
  - `IDLE`: on the first input transfer, latch `rate`, clear the shift register and reset the puncture phase, then go to `DATA`. If that bit also carries `di_last`, the frame is one bit long.
  - `DATA`: an input transfer with `di_last` moves to `TAIL` (tail on) or `IDLE` (tail off).
  - `TAIL`: injects K-1 internal zero bits, one per free slot, then returns to `IDLE`. `di_rdy` is 0 throughout `TAIL`.
- Encoding of each input bit u with shift register s (newest bit first):
  - A = ^(G0 & {u,s}), B = ^(G1 & {u,s}).
  - s <= {u, s[K-2:1]}.
- Puncturing: coded bits enter a 2-entry pending buffer with a keep mask. The phase counter wraps per the latched rate:
  - 1/2, period 1: keep A, keep B.
  - 2/3, period 2: phase 0 keeps A,B; phase 1 keeps A only.
  - 3/4, period 3: phase 0 keeps A,B; phase 1 keeps A only; phase 2 keeps B only.
  - Every input bit yields at least one coded bit. Emission order is always A before B.
  - Tail bits are punctured with the continuing phase.
- Buffer/ready rule: `di_rdy` = (not `TAIL`) & (pending==0 | (pending==1 & `do_rdy`)). This gives back-to-back loading when the last pending bit leaves.
- `do_last`: asserted with the final kept bit of the frame's last symbol. That is the last tail bit when tail is on, otherwise the `di_last` bit.
- `rate` changes mid-frame are ignored.

## Timing
- Reset values: `do`=0, `do_vld`=0, `do_last`=0. FSM=`IDLE`, shift register=0, phase=0, pending=0.
- `di_rdy` is a function of registered state and `do_rdy`, so it is 1 one cycle after reset release.
- Latency: a bit accepted at cycle N drives its first coded bit on `do` at cycle N+1.
- Throughput with `do_rdy` held at 1:
  - rate 1/2: 1 input per 2 cycles.
  - rate 2/3: 2 inputs per 3 cycles.
  - rate 3/4: 3 inputs per 4 cycles.
- With `do_vld`=1 and `do_rdy`=0, `do` and `do_last` hold stable.
- Asserting `rst` mid-frame aborts the frame immediately. Partial output is lost and there is no `do_last`.

## Configuration
- `CENC_TAIL_EN` defined: after `di_last`, K-1 zero tail bits are encoded and punctured, and `do_last` lands on the final tail coded bit.
- `CENC_TAIL_EN` undefined: no `TAIL` state, the encoder state is left unflushed, and `do_last` lands on the final coded bit of the `di_last` bit.

## Structure
- Package `cenc_pkg`:
  - rate enum (`RATE_1_2`, `RATE_2_3`, `RATE_3_4`).
  - default generators `CENC_G0`/`CENC_G1`.
  - puncture keep-mask constants per rate/phase.
- Sub-module `cenc_conv_core`: shift register plus the two parity trees, parametrised by K/G0/G1. It has load and clear inputs and A/B outputs.
- Top level holds the FSM, phase counter, pending buffer and handshakes.

## Test plan
All scenarios use K=7 and `CENC_TAIL_EN` defined unless stated.
- **Impulse, rate 1/2:** single bit 1 with `di_last` -> 14 bits 1,1,0,1,1,1,1,1,0,0,1,0,1,1, with `do_last` on the 14th.
- **Rate 3/4:** 3 data bits plus 6 tail bits -> exactly 12 output bits, matching the reference model, with `do_last` on the 12th.
- **Rate 2/3:** 4 data bits -> 15 output bits, pattern A,B,A repeating.
- **Backpressure:** random 64-bit frame at rate 1/2 with `do_rdy` low 5 cycles mid-frame -> `do` stable while stalled, `di_rdy`=0, output sequence identical to the unstalled run.
- **Reserved rate and back-to-back frames:** `rate`=3 -> output identical to rate 1/2. Two back-to-back frames -> the second starts at phase 0 with the shift register cleared.
- **Reset and tail-off build:** `rst` asserted mid-frame -> all outputs 0 next cycle, and a new frame encodes correctly. A build without `CENC_TAIL_EN` and an impulse at rate 1/2 -> 2 bits (1,1), with `do_last` on the 2nd.
